// File: rtl/arm_blk_pkg.sv
// Shared definitions for the ARM LDM/STM micro-op sequencer: FSM states and
// instruction field positions.
package arm_blk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2
    } blk_state_t;

    localparam int P_BIT    = 24;
    localparam int U_BIT    = 23;
    localparam int W_BIT    = 21;
    localparam int L_BIT    = 20;
    localparam int RN_LSB   = 16;
    localparam int LIST_LSB = 0;

    localparam logic [2:0] BLK_OPC = 3'b100;

endpackage

// File: rtl/lsb_enc16.sv
// Lowest-set-bit encoder: index of the lowest set bit, a found flag, and the
// input vector with that bit cleared.
module lsb_enc16 (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        found,
    output logic [15:0] rest
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
    end

    assign found = |vec;
    assign rest  = vec & (vec - 16'd1);

endmodule

// File: rtl/ldm_stm_seq.sv
// Decode-stage expander: turns an ARM LDM/STM into one memory micro-op per
// listed register plus an optional base-writeback micro-op.
module ldm_stm_seq
    import arm_blk_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        armD,
    input  logic [31:0] InstrD,
    input  logic        LdStallD,
    input  logic        FlushD,
    output logic        StallFD,
    output logic        UopValidD,
    output logic        UopLD,
    output logic        UopWbD,
    output logic [3:0]  UopRdD,
    output logic [3:0]  UopRnD,
    output logic [7:0]  UopOffsetD,
    output logic        UopFirstD,
    output logic        UopLastD
);

    blk_state_t  state;
    logic [15:0] mask_q;
    logic [7:0]  off_q;
    logic [4:0]  cnt_q;
    logic [3:0]  rn_q;
    logic        l_q, u_q, wb_q;

    logic        blk, p, u, w, l;
    logic [3:0]  rn;
    logic [15:0] list;
    logic [4:0]  n;
    logic [7:0]  n4, start_off, wb_off;
    logic        wb_need;

    logic [3:0]  idx_i, idx_m;
    logic        found_i, found_m;
    logic [15:0] rest_i, rest_m;

    assign blk  = armD && (InstrD[27:25] == BLK_OPC);
    assign p    = InstrD[P_BIT];
    assign u    = InstrD[U_BIT];
    assign w    = InstrD[W_BIT];
    assign l    = InstrD[L_BIT];
    assign rn   = InstrD[RN_LSB +: 4];
    assign list = InstrD[LIST_LSB +: 16];

    always_comb begin
        n = 5'd0;
        for (int i = 0; i < 16; i++) n = n + 5'(list[i]);
    end

    assign n4 = {1'b0, n, 2'b00};

    always_comb begin
        case ({p, u})
            2'b01:   start_off = 8'd0;
            2'b11:   start_off = 8'd4;
            2'b00:   start_off = 8'd4 - n4;
            default: start_off = 8'd0 - n4;
        endcase
    end

    // A loaded base would be overwritten by the transfer, so writeback is dropped.
    assign wb_need = w && (n != 5'd0) && !(l && list[rn]);
    assign wb_off  = u_q ? {1'b0, cnt_q, 2'b00} : 8'd0 - {1'b0, cnt_q, 2'b00};

    lsb_enc16 u_enc_instr (
        .vec   (list),
        .idx   (idx_i),
        .found (found_i),
        .rest  (rest_i)
    );

    lsb_enc16 u_enc_mask (
        .vec   (mask_q),
        .idx   (idx_m),
        .found (found_m),
        .rest  (rest_m)
    );

    always_comb begin
        UopValidD  = 1'b0;
        StallFD    = 1'b0;
        UopLD      = 1'b0;
        UopWbD     = 1'b0;
        UopRdD     = 4'd0;
        UopRnD     = 4'd0;
        UopOffsetD = 8'd0;
        UopFirstD  = 1'b0;
        if (!FlushD) begin
            case (state)
                IDLE: begin
                    if (blk && found_i) begin
                        UopValidD  = 1'b1;
                        UopLD      = l;
                        UopRdD     = idx_i;
                        UopRnD     = rn;
                        UopOffsetD = start_off;
                        UopFirstD  = 1'b1;
                        StallFD    = (rest_i != 16'd0) || wb_need;
                    end
                end
                XFER: begin
                    UopValidD  = found_m;
                    UopLD      = l_q;
                    UopRdD     = idx_m;
                    UopRnD     = rn_q;
                    UopOffsetD = off_q;
                    StallFD    = (rest_m != 16'd0) || wb_q;
                end
                WB: begin
                    UopValidD  = 1'b1;
                    UopLD      = l_q;
                    UopWbD     = 1'b1;
                    UopRdD     = rn_q;
                    UopRnD     = rn_q;
                    UopOffsetD = wb_off;
                end
                default: ;
            endcase
        end
    end

    assign UopLastD = UopValidD && !StallFD;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            mask_q <= 16'd0;
            off_q  <= 8'd0;
            cnt_q  <= 5'd0;
            rn_q   <= 4'd0;
            l_q    <= 1'b0;
            u_q    <= 1'b0;
            wb_q   <= 1'b0;
        end else if (FlushD) begin
            state  <= IDLE;
            mask_q <= 16'd0;
            off_q  <= 8'd0;
            wb_q   <= 1'b0;
        end else if (!LdStallD) begin
            case (state)
                IDLE: begin
                    if (blk && found_i && ((rest_i != 16'd0) || wb_need)) begin
                        mask_q <= rest_i;
                        off_q  <= start_off + 8'd4;
                        cnt_q  <= n;
                        rn_q   <= rn;
                        l_q    <= l;
                        u_q    <= u;
                        wb_q   <= wb_need;
                        state  <= (rest_i != 16'd0) ? XFER : WB;
                    end
                end
                XFER: begin
                    mask_q <= rest_m;
                    off_q  <= off_q + 8'd4;
                    if (rest_m == 16'd0) state <= wb_q ? WB : IDLE;
                end
                WB: begin
                    wb_q  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Bench for ldm_stm_seq: directed per-cycle vector table, reset mid-sequence,
// then random instructions checked against a micro-op list model.
module tb_ldm_stm_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        armD;
    logic [31:0] InstrD;
    logic        LdStallD;
    logic        FlushD;
    logic        StallFD, UopValidD, UopLD, UopWbD, UopFirstD, UopLastD;
    logic [3:0]  UopRdD, UopRnD;
    logic [7:0]  UopOffsetD;

    always #5 clk = ~clk;

    ldm_stm_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .armD       (armD),
        .InstrD     (InstrD),
        .LdStallD   (LdStallD),
        .FlushD     (FlushD),
        .StallFD    (StallFD),
        .UopValidD  (UopValidD),
        .UopLD      (UopLD),
        .UopWbD     (UopWbD),
        .UopRdD     (UopRdD),
        .UopRnD     (UopRnD),
        .UopOffsetD (UopOffsetD),
        .UopFirstD  (UopFirstD),
        .UopLastD   (UopLastD)
    );

    // Output bundle: {valid, stall, ld, wb, rd, rn, offset, first, last}
    logic [21:0] act;
    assign act = {UopValidD, StallFD, UopLD, UopWbD, UopRdD, UopRnD,
                  UopOffsetD, UopFirstD, UopLastD};

    typedef struct {
        logic        arm;
        logic [31:0] instr;
        logic        lds;
        logic        fl;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    // Model micro-op: {ld, wb, rd, rn, offset}
    logic [17:0] exp_q[$];
    int          idx;

    function automatic logic [21:0] pk(logic v, logic st, logic ld, logic wb,
                                       logic [3:0] rd, logic [3:0] rn,
                                       logic [7:0] off, logic f, logic la);
        return {v, st, ld, wb, rd, rn, off, f, la};
    endfunction

    task automatic add(logic arm, logic [31:0] instr, logic lds, logic fl,
                       logic [21:0] exp);
        vec_t t;
        t.arm = arm; t.instr = instr; t.lds = lds; t.fl = fl; t.exp = exp;
        tbl.push_back(t);
    endtask

    task automatic chk(string name, logic [21:0] a, logic [21:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic drive(logic arm, logic [31:0] instr, logic lds, logic fl);
        armD = arm; InstrD = instr; LdStallD = lds; FlushD = fl;
    endtask

    // Builds the full micro-op list for one instruction from the ISA rules.
    task automatic build(logic arm, logic [31:0] instr);
        logic [15:0] list;
        logic        p, u, w, l;
        logic [3:0]  rn;
        int          n, base, k;
        exp_q.delete();
        if (!(arm && instr[27:25] == 3'b100)) return;
        list = instr[15:0];
        n = $countones(list);
        if (n == 0) return;
        p = instr[24]; u = instr[23]; w = instr[21]; l = instr[20];
        rn = instr[19:16];
        if (u) base = p ? 4 : 0;
        else   base = p ? -4 * n : -4 * n + 4;
        k = 0;
        for (int r = 0; r < 16; r++) begin
            if (list[r]) begin
                exp_q.push_back({l, 1'b0, 4'(r), rn, 8'(base + 4 * k)});
                k++;
            end
        end
        if (w && !(l && list[rn]))
            exp_q.push_back({l, 1'b1, rn, rn, 8'(u ? 4 * n : -4 * n)});
    endtask

    initial begin
        logic [21:0] z;
        logic        arm_r, lds_r, fl_r, st;
        logic [31:0] ins_r;
        logic [21:0] e;
        logic [17:0] m;
        z = 22'd0;

        // LDMIA R0,{R1,R2,R3}
        add(1, 32'hE890000E, 0, 0, pk(1,1,1,0, 1, 0, 8'h00, 1,0));
        add(1, 32'hE890000E, 0, 0, pk(1,1,1,0, 2, 0, 8'h04, 0,0));
        add(1, 32'hE890000E, 0, 0, pk(1,0,1,0, 3, 0, 8'h08, 0,1));
        // STMDB R13!,{R4,R5,R14}
        add(1, 32'hE92D4030, 0, 0, pk(1,1,0,0, 4, 13, 8'hF4, 1,0));
        add(1, 32'hE92D4030, 0, 0, pk(1,1,0,0, 5, 13, 8'hF8, 0,0));
        add(1, 32'hE92D4030, 0, 0, pk(1,1,0,0, 14, 13, 8'hFC, 0,0));
        add(1, 32'hE92D4030, 0, 0, pk(1,0,0,1, 13, 13, 8'hF4, 0,1));
        // LDMIA R2!,{R2,R7}: base loaded, no writeback
        add(1, 32'hE8B20084, 0, 0, pk(1,1,1,0, 2, 2, 8'h00, 1,0));
        add(1, 32'hE8B20084, 0, 0, pk(1,0,1,0, 7, 2, 8'h04, 0,1));
        // LDMIB R1,{} and non-block / non-ARM words
        add(1, 32'hE9910000, 0, 0, z);
        add(1, 32'hE0810002, 0, 0, z);
        add(0, 32'hE890000E, 0, 0, z);
        // LDMDA R3,{R1,R2}
        add(1, 32'hE8130006, 0, 0, pk(1,1,1,0, 1, 3, 8'hFC, 1,0));
        add(1, 32'hE8130006, 0, 0, pk(1,0,1,0, 2, 3, 8'h00, 0,1));
        // STMIA R1!,{R1}: store of base keeps writeback
        add(1, 32'hE8A10002, 0, 0, pk(1,1,0,0, 1, 1, 8'h00, 1,0));
        add(1, 32'hE8A10002, 0, 0, pk(1,0,0,1, 1, 1, 8'h04, 0,1));
        // LDMIA R0,{R0-R3} with a 2-cycle load-use stall on the 2nd micro-op
        add(1, 32'hE890000F, 0, 0, pk(1,1,1,0, 0, 0, 8'h00, 1,0));
        add(1, 32'hE890000F, 1, 0, pk(1,1,1,0, 1, 0, 8'h04, 0,0));
        add(1, 32'hE890000F, 1, 0, pk(1,1,1,0, 1, 0, 8'h04, 0,0));
        add(1, 32'hE890000F, 0, 0, pk(1,1,1,0, 1, 0, 8'h04, 0,0));
        add(1, 32'hE890000F, 0, 0, pk(1,1,1,0, 2, 0, 8'h08, 0,0));
        add(1, 32'hE890000F, 0, 0, pk(1,0,1,0, 3, 0, 8'h0C, 0,1));
        // Flush on the 2nd of 4 micro-ops, then a fresh STMIA R5,{R6}
        add(1, 32'hE890000F, 0, 0, pk(1,1,1,0, 0, 0, 8'h00, 1,0));
        add(1, 32'hE890000F, 1, 1, z);
        add(1, 32'hE8850040, 0, 0, pk(1,0,0,0, 6, 5, 8'h00, 1,1));
        // LDMIA R0,{R1,R15}: PC last
        add(1, 32'hE8908002, 0, 0, pk(1,1,1,0, 1, 0, 8'h00, 1,0));
        add(1, 32'hE8908002, 0, 0, pk(1,0,1,0, 15, 0, 8'h04, 0,1));
        // Flush during writeback
        add(1, 32'hE8A10002, 0, 0, pk(1,1,0,0, 1, 1, 8'h00, 1,0));
        add(1, 32'hE8A10002, 0, 1, z);
        add(0, 32'h00000013, 0, 0, z);

        drive(0, 32'h0, 0, 0);
        reset_n = 1'b0;
        #1 chk("reset_state", act, z);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i].arm, tbl[i].instr, tbl[i].lds, tbl[i].fl);
            @(negedge clk);
            chk($sformatf("vec%0d", i), act, tbl[i].exp);
        end

        // Asynchronous reset while in the middle of a transfer
        @(posedge clk); #1;
        drive(1, 32'hE890000F, 0, 0);
        @(negedge clk);
        chk("rst_seq_first", act, pk(1,1,1,0, 0, 0, 8'h00, 1,0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_seq_second", act, pk(1,1,1,0, 1, 0, 8'h04, 0,0));
        #2 reset_n = 1'b0;
        #1 chk("rst_async_idle", act, pk(1,1,1,0, 0, 0, 8'h00, 1,0));
        drive(1, 32'hE0810002, 0, 0);
        #1 chk("rst_nonblock", act, z);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_released", act, z);

        // Random instructions against the micro-op list model
        exp_q.delete();
        idx = 0;
        arm_r = 0; ins_r = 32'h0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                arm_r = ($urandom_range(0, 9) != 0);
                ins_r = $urandom;
                if ($urandom_range(0, 3) != 0) ins_r[27:25] = 3'b100;
                case ($urandom_range(0, 9))
                    0:       ins_r[15:0] = 16'h0000;
                    1:       ins_r[15:0] = 16'hFFFF;
                    default: ins_r[15:0] = 16'($urandom & $urandom & $urandom);
                endcase
                build(arm_r, ins_r);
                idx = 0;
            end
            lds_r = ($urandom_range(0, 4) == 0);
            fl_r  = ($urandom_range(0, 24) == 0);
            drive(arm_r, ins_r, lds_r, fl_r);
            if (fl_r) begin
                e = z;
                exp_q.delete();
            end else if (exp_q.size() == 0) begin
                e = z;
            end else begin
                m  = exp_q[idx];
                st = (idx < exp_q.size() - 1);
                e  = pk(1'b1, st, m[17], m[16], m[15:12], m[11:8], m[7:0],
                        idx == 0, !st);
                if (!lds_r) begin
                    idx++;
                    if (idx == exp_q.size()) exp_q.delete();
                end
            end
            @(negedge clk);
            chk($sformatf("rand%0d", c), act, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
